// File: rtl/cpu_pkg.sv
// Shared widths, jump encodings and fetch FSM states.
// Imported by fetch_unit and pc_next.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 6;

    typedef enum logic [1:0] {
        J_SEQ = 2'b00,
        J_IMM = 2'b01,
        J_REG = 2'b10,
        J_RSV = 2'b11
    } jump_e;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: jump-imm, jump-reg, branch, else pc+4; word aligned.
// In: pc_plus4, target26, jump, pcsrc, targets. Out: next_pc.
module pc_next
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [25:0]     target26,
    input  logic [1:0]      jump,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_reg_target,
    output logic [XLEN-1:0] next_pc
);

    logic            sel_imm;
    logic            sel_reg;
    logic            sel_br;
    logic            sel_seq;
    logic [XLEN-1:0] raw;

    // One-hot selects; jumps win over the branch, and the
    // reserved jump code falls through like sequential.
    assign sel_imm = (jump == J_IMM);
    assign sel_reg = (jump == J_REG);
    assign sel_br  = pcsrc && !sel_imm && !sel_reg;
    assign sel_seq = !sel_imm && !sel_reg && !sel_br;

    always_comb begin
        raw = pc_plus4;
        unique case (1'b1)
            sel_imm: raw = {pc_plus4[31:28], target26, 2'b00};
            sel_reg: raw = jump_reg_target;
            sel_br:  raw = branch_target;
            sel_seq: raw = pc_plus4;
            default: raw = pc_plus4;
        endcase
    end

    assign next_pc = raw & 32'hFFFF_FFFC;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: BOOT -> FETCH -> VALID loop.
// imem_* request port, stall/PcSrc/Jump consume side, instr/op/pc out.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PcSrc,
    input  logic [1:0]  Jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_reg_target,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [31:0] retired
);

    fetch_state_e state;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign op        = instr[31:32-OPW];

    pc_next u_pc_next (
        .pc_plus4        (pc_plus4),
        .target26        (instr[25:0]),
        .jump            (Jump),
        .pcsrc           (PcSrc),
        .branch_target   (branch_target),
        .jump_reg_target (jump_reg_target),
        .next_pc         (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            instr       <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state       <= S_VALID;
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_VALID: begin
                    // Control inputs only matter on the consume edge.
                    if (!stall) begin
                        state       <= S_FETCH;
                        pc          <= next_pc;
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_BOOT;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Transaction-level bench for fetch_unit: memory/consumer model.
// Directed scenarios followed by randomized fetch/stall/redirect traffic.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        PcSrc = 1'b0;
    logic [1:0]  Jump = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_reg_target = '0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .PcSrc           (PcSrc),
        .Jump            (Jump),
        .branch_target   (branch_target),
        .jump_reg_target (jump_reg_target),
        .instr           (instr),
        .op              (op),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .retired         (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Where the next fetch should go, from the redirect rules.
    function automatic logic [31:0] model_next(
        input logic [31:0] cur, input logic [31:0] ins,
        input logic [1:0] j, input logic ps,
        input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] p4;
        p4 = cur + 32'd4;
        if (j == 2'd1)
            return (p4 & 32'hF000_0000) |
                   ((ins & 32'h03FF_FFFF) << 2);
        if (j == 2'd2)
            return jt & ~32'd3;
        if (ps)
            return bt & ~32'd3;
        return p4;
    endfunction

    task automatic noise_ctrl();
        Jump = 2'($urandom);
        PcSrc = 1'($urandom);
        branch_target = $urandom;
        jump_reg_target = $urandom;
    endtask

    task automatic check_reset_outs(input string t);
        check({t, "_req"}, 32'(imem_req), 0);
        check({t, "_vld"}, 32'(instr_valid), 0);
        check({t, "_op"}, 32'(op), 0);
        check({t, "_instr"}, instr, 0);
        check({t, "_pc"}, pc, RPC);
        check({t, "_ret"}, retired, 0);
    endtask

    // Called at a negedge; asserts reset asynchronously, feeds a
    // spurious ready, releases and checks the single BOOT cycle.
    task automatic do_reset(input string t);
        reset = 1'b1;
        #1;
        check_reset_outs({t, "_async"});
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        check_reset_outs({t, "_hold"});
        reset = 1'b0;
        imem_ready = 1'b0;
        exp_pc = RPC;
        exp_ret = 0;
        check({t, "_boot_req"}, 32'(imem_req), 0);
        check({t, "_boot_vld"}, 32'(instr_valid), 0);
        @(negedge clk);
    endtask

    // One full transaction: dly not-ready cycles, nst stall cycles,
    // then a consume with the given redirect controls.
    task automatic run_fetch(input logic [31:0] data,
                             input int dly, input int nst,
                             input logic [1:0] j, input logic ps,
                             input logic [31:0] bt,
                             input logic [31:0] jt);
        for (int i = 0; i <= dly; i++) begin
            check("f_req", 32'(imem_req), 1);
            check("f_addr", imem_addr, exp_pc);
            check("f_vld", 32'(instr_valid), 0);
            imem_ready = (i == dly);
            imem_rdata = (i == dly) ? data : $urandom;
            stall = 1'($urandom);
            noise_ctrl();
            @(negedge clk);
        end
        for (int s = 0; s <= nst; s++) begin
            check("v_vld", 32'(instr_valid), 1);
            check("v_req", 32'(imem_req), 0);
            check("v_instr", instr, data);
            check("v_op", 32'(op), 32'(data[31:26]));
            check("v_pc", pc, exp_pc);
            check("v_pc4", pc_plus4, exp_pc + 32'd4);
            check("v_ret", retired, exp_ret);
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            if (s < nst) begin
                stall = 1'b1;
                noise_ctrl();
            end else begin
                stall = 1'b0;
                Jump = j;
                PcSrc = ps;
                branch_target = bt;
                jump_reg_target = jt;
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        exp_pc = model_next(exp_pc, data, j, ps, bt, jt);
        exp_ret = exp_ret + 32'd1;
        check("c_ret", retired, exp_ret);
    endtask

    initial begin
        logic [31:0] d;
        @(negedge clk);
        do_reset("rst0");

        for (int k = 0; k < 4; k++)
            run_fetch($urandom, 0, 0, 2'd0, 1'b0, 0, 0);
        check("seq_pc", pc, 32'h10);
        check("seq_ret", retired, 4);

        run_fetch(32'h8C01_0004, 3, 0, 2'd0, 1'b0, 0, 0);

        exp_pc = exp_pc;
        run_fetch(32'h1234_5678, 0, 5, 2'd0, 1'b0, 32'h100, 0);

        run_fetch($urandom, 1, 0, 2'd2, 1'b1,
                  32'h300, 32'h1000_0010);
        check("jr_pc", pc, 32'h1000_0010);
        d = 32'h0800_0040;
        run_fetch(d, 0, 1, 2'd1, 1'b1, 32'h300, 32'h500);
        check("jimm_pc", pc, 32'h1000_0100);
        run_fetch($urandom, 0, 0, 2'd2, 1'b0, 0, 32'h203);
        check("jr_align", pc, 32'h200);
        run_fetch($urandom, 0, 0, 2'd3, 1'b0, 32'h700, 0);
        check("j11_pc", pc, 32'h204);

        run_fetch($urandom, 0, 0, 2'd2, 1'b0, 0, 32'hFFFF_FFFC);
        run_fetch($urandom, 2, 0, 2'd0, 1'b0, 0, 0);
        check("wrap_pc", pc, 0);

        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset("rst_fetch");
        run_fetch($urandom, 0, 0, 2'd0, 1'b0, 0, 0);

        imem_ready = 1'b1;
        imem_rdata = $urandom;
        stall = 1'b1;
        @(negedge clk);
        check("pre_rst_vld", 32'(instr_valid), 1);
        @(negedge clk);
        do_reset("rst_stall");

        for (int k = 0; k < 40; k++)
            run_fetch($urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), 2'($urandom),
                      1'($urandom), $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded by reset.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1, meaning instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, meaning word-aligned fetch address, equal to pc.
REQ-006 SHALL have port imem_ready, input, 1, meaning imem_rdata valid for the current request this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, meaning fetched instruction word.
REQ-008 SHALL have port stall, input, 1, meaning downstream cannot consume the held instruction this cycle.
REQ-009 SHALL have port PcSrc, input, 1, meaning taken branch from the controller for the held instruction.
REQ-010 SHALL have port Jump, input, 2, meaning 00 sequential, 01 jump immediate, 10 jump register, 11 reserved.
REQ-011 SHALL have port branch_target, input, 32, meaning branch destination from the datapath.
REQ-012 SHALL have port jump_reg_target, input, 32, meaning register-jump destination.
REQ-013 SHALL have port instr, output, 32, meaning held instruction word.
REQ-014 SHALL have port op, output, 6, meaning instr[31:26], fed to the controller.
REQ-015 SHALL have port pc, output, 32, meaning address of the held or in-flight instruction.
REQ-016 SHALL have port pc_plus4, output, 32, meaning pc + 4, modulo 2^32.
REQ-017 SHALL have port instr_valid, output, 1, meaning instr/op are valid and awaiting consumption.
REQ-018 SHALL have port retired, output, 32, meaning count of consumed instructions.

Function
REQ-019 SHALL implement a three-state FSM: BOOT, FETCH, VALID.
REQ-020 BOOT SHALL last exactly one cycle after reset release, then go to FETCH; imem_req=0 in BOOT.
REQ-021 FETCH SHALL drive imem_req=1 and imem_addr=pc; stay in FETCH while imem_ready=0.
REQ-022 FETCH with imem_ready=1 SHALL latch imem_rdata into instr and go to VALID next cycle; minimum fetch latency is 1 cycle (ready in the first FETCH cycle).
REQ-023 imem_ready SHALL be ignored outside FETCH.
REQ-024 VALID SHALL drive instr_valid=1, imem_req=0; stay in VALID, holding instr and pc, while stall=1.
REQ-025 VALID with stall=0 (consume) SHALL load pc with next_pc, increment retired, and go to FETCH.
REQ-026 PcSrc, Jump, and targets SHALL be sampled only in the consume cycle; ignored otherwise.
REQ-027 next_pc priority SHALL be: Jump=01 -> {pc_plus4[31:28], instr[25:0], 2'b00}; Jump=10 -> jump_reg_target; PcSrc=1 -> branch_target; otherwise pc_plus4.
REQ-028 Jump=11 SHALL be treated as 00.
REQ-029 Bits [1:0] of any next_pc SHALL be forced to 0.
REQ-030 pc SHALL wrap from 32'hFFFF_FFFC to 0 on sequential advance.
REQ-031 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-032 Only one fetch SHALL be outstanding; no new request is issued until the held instruction is consumed.

Reset
REQ-033 Reset SHALL asynchronously force state=BOOT, pc=RESET_PC, instr=0, retired=0.
REQ-034 During reset, outputs SHALL be imem_req=0, instr_valid=0, op=0, instr=0, pc=RESET_PC.
REQ-035 Reset asserted mid-fetch or mid-stall SHALL abandon the request and held instruction; a late imem_ready SHALL be ignored.

Structure
REQ-036 Package cpu_pkg SHALL hold instruction width (32), opcode field width (6), the Jump encodings, and the FSM state enum.
REQ-037 One combinational sub-module, pc_next, SHALL implement REQ-027 through REQ-029; FSM and registers live in fetch_unit.

Verification
REQ-038 Reset, then imem_ready=1 every cycle, stall=0, Jump=00, PcSrc=0 -> addresses 0,4,8,C; retired=4 after the fourth consume; instr_valid each second cycle.
REQ-039 imem_ready held 0 for 3 FETCH cycles, then 1 with rdata=32'h8C01_0004 -> imem_req high 4 cycles; op=6'h23 valid next cycle.
REQ-040 stall=1 for 5 VALID cycles, PcSrc=1 with branch_target=32'h100 during the stall and then stall=0 with PcSrc=0 -> instr held unchanged; next fetch at pc_plus4, not 0x100.
REQ-041 Consume at pc=32'h1000_0010 with Jump=01, instr[25:0]=26'h40, and PcSrc=1 -> next fetch at 32'h1000_0100.
REQ-042 Jump=10 with jump_reg_target=32'h203 -> next fetch at 32'h200; Jump=11 -> pc_plus4.
REQ-043 Reset asserted while in FETCH with imem_ready arriving during reset -> instr_valid=0; BOOT one cycle; next fetch at RESET_PC.
